// File: rtl/engine_rev_sequencer.sv
// rtl/engine_rev_sequencer.sv - engine-rev pulse sequencer with slewed period
// Converts a CPU motor speed to a tick period and emits one-tick rev pulses at a slewed rate.
module engine_rev_sequencer #(
  parameter int MIN_PERIOD = 100,
  parameter int STEP       = 4,
  parameter int SLEW       = 8,
  parameter int PW         = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_3MHz_en,
  input  logic          enable,
  input  logic          wr_en,
  input  logic [7:0]    wr_speed,
  output logic          engine_rev_en,
  output logic [PW-1:0] cur_period,
  output logic [PW-1:0] target_period,
  output logic          busy
);

  localparam logic [PW-1:0] MIN_P      = PW'(MIN_PERIOD);
  localparam logic [PW-1:0] STEP_P     = PW'(STEP);
  localparam logic [PW-1:0] SLEW_P     = PW'(SLEW);
  localparam logic [PW-1:0] MAX_PERIOD = PW'(MIN_PERIOD + 255 * STEP);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    speed;
  logic [PW-1:0] count;
  logic [PW-1:0] count_next;
  logic [PW-1:0] cur_next;
  logic          rev_next;
  logic [PW-1:0] speed_gap;
  logic [PW-1:0] target_calc;
  logic [PW-1:0] slew_gap;
  logic [PW-1:0] slewed;
  logic          terminal;

  // Target is recomputed every cycle from the speed register, giving the
  // one-clock latency between a write and the new target.
  assign speed_gap   = {{(PW-8){1'b0}}, 8'd255 - speed};
  assign target_calc = MIN_P + speed_gap * STEP_P;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed         <= 8'd0;
      target_period <= MAX_PERIOD;
    end else begin
      if (wr_en) begin
        speed <= wr_speed;
      end
      target_period <= target_calc;
    end
  end

  // Step toward the target by at most SLEW; the gap form cannot wrap.
  always_comb begin
    slew_gap = '0;
    slewed   = cur_period;
    if (cur_period < target_period) begin
      slew_gap = target_period - cur_period;
      slewed   = (slew_gap > SLEW_P) ? (cur_period + SLEW_P) : target_period;
    end else if (cur_period > target_period) begin
      slew_gap = cur_period - target_period;
      slewed   = (slew_gap > SLEW_P) ? (cur_period - SLEW_P) : target_period;
    end
  end

  assign terminal = (count == (cur_period - PW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      count         <= '0;
      cur_period    <= MAX_PERIOD;
      engine_rev_en <= 1'b0;
    end else begin
      state         <= state_next;
      count         <= count_next;
      cur_period    <= cur_next;
      engine_rev_en <= rev_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    cur_next   = cur_period;
    rev_next   = engine_rev_en;
    if (clk_3MHz_en) begin
      case (state)
        IDLE: begin
          count_next = '0;
          rev_next   = 1'b0;
          if (enable) begin
            state_next = RUN;
            cur_next   = target_period;
            rev_next   = 1'b1;
          end
        end
        RUN: begin
          if (!enable) begin
            state_next = IDLE;
            count_next = '0;
            rev_next   = 1'b0;
          end else if (terminal) begin
            count_next = '0;
            rev_next   = 1'b1;
            cur_next   = slewed;
          end else begin
            count_next = count + PW'(1);
            rev_next   = 1'b0;
          end
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
          rev_next   = 1'b0;
        end
      endcase
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_engine_rev_sequencer.sv
// tb/tb_engine_rev_sequencer.sv - directed self-checking bench for engine_rev_sequencer
module tb_engine_rev_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk_3MHz_en = 1'b0;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_speed = 8'd0;
  logic        engine_rev_en;
  logic [15:0] cur_period;
  logic [15:0] target_period;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int tick_div = 1;
  int tick_phase = 0;
  logic prev_rev = 1'b0;
  int rise_q[$];
  int fall_q[$];

  engine_rev_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clk_3MHz_en   (clk_3MHz_en),
    .enable        (enable),
    .wr_en         (wr_en),
    .wr_speed      (wr_speed),
    .engine_rev_en (engine_rev_en),
    .cur_period    (cur_period),
    .target_period (target_period),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tick qualifier and pulse-edge monitor, both on the inactive edge.
  always @(negedge clk) begin
    tick_phase  = (tick_phase + 1) % tick_div;
    clk_3MHz_en = (tick_phase == 0);
    if (engine_rev_en && !prev_rev) rise_q.push_back(cyc);
    if (!engine_rev_en && prev_rev) fall_q.push_back(cyc);
    prev_rev = engine_rev_en;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic write_speed(input logic [7:0] s);
    @(negedge clk);
    wr_en    = 1'b1;
    wr_speed = s;
    @(negedge clk);
    wr_en    = 1'b0;
  endtask

  task automatic wait_rises(input string tag, input int n, input int budget);
    int k;
    k = 0;
    while (rise_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, rise_q.size() >= n, 1);
  endtask

  function automatic int gap(input int i);
    return (rise_q.size() > i + 1) ? (rise_q[i+1] - rise_q[i]) : 0;
  endfunction

  initial begin
    int expv[5];
    int start;

    // Reset and idle hold
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("rst_rev", engine_rev_en, 0);
      check("rst_busy", busy, 0);
      check("rst_cur", cur_period, 1120);
      check("rst_tgt", target_period, 1120);
    end

    // Steady rate at speed 255
    write_speed(8'd255);
    check("tgt_lat_old", target_period, 1120);
    @(negedge clk);
    check("tgt_lat_new", target_period, 100);
    rise_q.delete();
    enable = 1'b1;
    @(negedge clk);
    check("entry_rev", engine_rev_en, 1);
    check("entry_busy", busy, 1);
    check("entry_cur", cur_period, 100);
    wait_rises("steady_to", 4, 500);
    for (int i = 0; i < 3; i++) check("steady_gap", gap(i), 100);
    check("steady_cur", cur_period, 100);

    // Slew from 100 toward 120
    rise_q.delete();
    wait_rises("slew_p0_to", 1, 200);
    write_speed(8'd250);
    wait_rises("slew_to", 6, 1000);
    expv = '{100, 108, 116, 120, 120};
    for (int i = 0; i < 5; i++) check("slew_gap", gap(i), expv[i]);
    check("slew_cur", cur_period, 120);
    check("slew_tgt", target_period, 120);

    // Sparse ticks: one in four clocks
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("sparse_idle", busy, 0);
    write_speed(8'd255);
    tick_div = 4;
    repeat (8) @(negedge clk);
    rise_q.delete();
    fall_q.delete();
    enable = 1'b1;
    wait_rises("sparse_to", 3, 1500);
    check("sparse_gap0", gap(0), 400);
    check("sparse_gap1", gap(1), 400);
    check("sparse_width", (fall_q.size() > 0) ? (fall_q[0] - rise_q[0]) : 0, 4);
    check("sparse_cur", cur_period, 100);

    // Enable drop at counter 50, restart at speed 0
    tick_div = 1;
    repeat (4) @(negedge clk);
    rise_q.delete();
    wait_rises("drop_p_to", 1, 200);
    start = (rise_q.size() > 0) ? rise_q[rise_q.size()-1] : cyc;
    while (cyc < start + 50) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("drop_busy", busy, 0);
    check("drop_rev", engine_rev_en, 0);
    write_speed(8'd0);
    rise_q.delete();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("off_busy", busy, 0);
      check("off_rev", engine_rev_en, 0);
    end
    check("off_cur", cur_period, 100);
    check("off_pulses", rise_q.size(), 0);
    check("off_tgt", target_period, 1120);
    enable = 1'b1;
    @(negedge clk);
    check("restart_rev", engine_rev_en, 1);
    check("restart_busy", busy, 1);
    check("restart_cur", cur_period, 1120);

    // Asynchronous reset while the pulse is high
    #1 rst_n = 1'b0;
    #1;
    check("arst_rev", engine_rev_en, 0);
    check("arst_busy", busy, 0);
    check("arst_cur", cur_period, 1120);
    check("arst_tgt", target_period, 1120);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
